median_window_filter: RTL and testbench
=======================================

# median_window_filter

Streaming sliding-window median filter for the image/sample pipeline, the parametrised successor to the fixed 9-tap, 8-bit median sorter. It accepts one sample per valid/ready handshake into an N-deep window. Once the window is full, every accepted sample triggers an iterative odd-even transposition sort and a median result on a valid/ready output port. It sits between the sample source and downstream consumers, and supports backpressure and a synchronous flush between frames.

## Interface
- `W`, default 8: sample width in bits; unsigned.
- `N`, default 9: window depth; must be odd, range 3..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset; clears all state.
- `flush` input 1: synchronous; empties the window and aborts any sort/output in progress.
- `in_valid` input 1: `data_in` is valid.
- `in_ready` output 1: block can accept a sample.
- `data_in` input W: input sample.
- `out_valid` output 1: `data_out` holds a median.
- `out_ready` input 1: consumer accepts the result.
- `data_out` output W: median of the current window.
- `min_out` output W: window minimum; present only with `MEDIAN_MINMAX_EN`.
- `max_out` output W: window maximum; present only with `MEDIAN_MINMAX_EN`.

## Operation
- **Storage**
  - Window `win[0..N-1]` is a shift register; the newest sample enters `win[0]` and the oldest is dropped from `win[N-1]`.
  - Fill counter is `$clog2(N+1)` bits and saturates at N.
- **FSM states**
  - IDLE
    - `in_ready` = 1.
    - On accept (`in_valid` && `in_ready`): shift in the sample and increment the fill counter.
    - If the window is full after this shift (fill reaches N, or was already N): copy the shifted window into sort array `srt[0..N-1]`, clear the pass counter, go to SORT.
    - Otherwise stay in IDLE and produce no output.
  - SORT
    - `in_ready` = 0.
    - One pass per cycle; N passes total; the pass counter selects the phase.
    - Even pass: compare/swap pairs (0,1),(2,3),…
    - Odd pass: compare/swap pairs (1,2),(3,4),…
    - Swap only when `srt[i] > srt[i+1]` (unsigned, strict), so equal values never move.
    - After pass N-1 go to OUT.
  - OUT
    - `in_ready` = 0; `out_valid` = 1.
    - `data_out` = `srt[(N-1)/2]`, registered and held stable while `out_ready` = 0.
    - On `out_valid` && `out_ready`: go to IDLE.
- **Window retention**: the window is not cleared after output. Sliding continues, so every accepted sample after the first N-1 yields exactly one median.
- **flush**
  - Has priority over any handshake in the same cycle.
  - Clears the fill counter, drops `out_valid`, and returns to IDLE.
  - A sample offered in the same cycle is not accepted.
- **Reset values**: `in_ready` = 0 while reset is asserted, then 1 from the first cycle after release. `out_valid`, `data_out`, `min_out`, `max_out`, fill counter, pass counter, `win` and `srt` are all 0. State = IDLE.

## Timing
- Accepting edge E0 loads `srt`; passes occur at edges E1..EN.
- `out_valid` rises at EN: N cycles after the accepting edge.
- Minimum period is N+2 cycles per median: accept cycle, N sort cycles, output cycle with `out_ready` = 1, then the next accept is possible in IDLE.
- `in_ready` and `out_valid` are never both 1.
- Backpressure: `out_valid` and `data_out` stay constant until the handshake; no data is lost.
- Reset asserted mid-SORT or mid-OUT:
  - Outputs clear immediately, without waiting for a clock.
  - The first sample after release starts a fresh fill; N samples are needed before the next median.

## Configuration
- `MEDIAN_MINMAX_EN` defined:
  - Adds ports `min_out` = `srt[0]` and `max_out` = `srt[N-1]`.
  - Both are valid and held under the same `out_valid`/`out_ready` rules as `data_out`.
- `MEDIAN_MINMAX_EN` undefined: the ports and their registers do not exist; all other behaviour is identical.

## Test plan
- N=5, W=8: push 10,50,30,20,40 with `out_ready` = 1 → no output for the first 4 samples; `data_out` = 30 with `out_valid` 5 cycles after the 5th accept.
- Continue by pushing 60 → window {50,30,20,40,60}; `data_out` = 40. Push 40,40 → duplicates handled, `data_out` = 40.
- Hold `out_ready` = 0 for 10 cycles after `out_valid` → `data_out` stable, `in_ready` = 0 throughout; release → exactly one handshake, then `in_ready` = 1.
- Pulse `flush` with 3 samples in the window, then push 1,2,3,4,5 → first median = 3, appearing only after the 5th post-flush sample.
- Assert `reset` low during SORT cycle 2 → `out_valid` and `data_out` drop to 0 asynchronously; after release, 5 new samples are required before any output.
- With `MEDIAN_MINMAX_EN` defined, push 7,255,0,128,3 → `data_out` = 7, `min_out` = 0, `max_out` = 255.

Source files
------------

// File: rtl/median_window_filter.sv
// median_window_filter
//   Streaming sliding-window median. Samples shift into an N-deep window;
//   once the window is full, every accepted sample copies the window into a
//   sort array. That array is ordered by N passes of odd-even transposition
//   (one pass per cycle), and the middle element is presented on a
//   valid/ready output port.
//   Optional build macro: MEDIAN_MINMAX_EN adds min_out/max_out ports that
//   carry the window minimum and maximum alongside the median.

// One compare/swap lane. Equal inputs pass straight through.
module median_cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  logic swap;

  // Strict unsigned compare: only an out-of-order pair is exchanged.
  always_comb begin
    swap = (a > b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

module median_window_filter #(
  parameter int W = 8,
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [W-1:0] min_out,
  output logic [W-1:0] max_out
`endif
);
  localparam int FW  = $clog2(N + 1);
  localparam int PW  = $clog2(N + 1);
  localparam int MID = (N - 1) / 2;

  typedef enum logic [1:0] {IDLE, SORT, OUT} state_t;

  state_t                state;
  logic [FW-1:0]         fill_cnt;
  logic [PW-1:0]         pass_cnt;
  logic [N-1:0][W-1:0]   win;
  logic [N-1:0][W-1:0]   win_sh;
  logic [N-1:0][W-1:0]   srt;
  logic [N-1:0][W-1:0]   srt_nxt;
  logic [N-2:0][W-1:0]   lo;
  logic [N-2:0][W-1:0]   hi;
  logic                  phase;
  logic                  accept;
  logic                  full_after;
  logic                  last_pass;

  assign phase      = pass_cnt[0];
  assign accept     = in_valid && in_ready;
  // Window is full after this shift if it already held N-1 or N samples.
  assign full_after = (fill_cnt >= FW'(N - 1));
  assign last_pass  = (pass_cnt == PW'(N - 1));

  // Window as it looks after shifting in data_in (newest at index 0).
  always_comb begin
    win_sh[0] = data_in;
    for (int i = 1; i < N; i++) win_sh[i] = win[i-1];
  end

  // One compare/swap lane per adjacent pair of the sort array.
  for (genvar i = 0; i < N - 1; i++) begin : g_cs
    median_cmp_swap #(.W(W)) u_cs (
      .a  (srt[i]),
      .b  (srt[i+1]),
      .lo (lo[i]),
      .hi (hi[i])
    );
  end

  // Per-element pass result: even passes pair (0,1),(2,3)..., odd passes
  // pair (1,2),(3,4)... With N odd, element 0 idles on odd passes and
  // element N-1 idles on even passes.
  for (genvar j = 0; j < N; j++) begin : g_el
    if (j == 0) begin : g_first
      assign srt_nxt[j] = phase ? srt[j] : lo[j];
    end else if (j == N - 1) begin : g_last
      assign srt_nxt[j] = phase ? hi[j-1] : srt[j];
    end else begin : g_mid
      assign srt_nxt[j] = (phase == ((j % 2) == 1)) ? lo[j] : hi[j-1];
    end
  end

  // Control FSM, window/sort storage and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      pass_cnt  <= '0;
      win       <= '0;
      srt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
`ifdef MEDIAN_MINMAX_EN
      min_out   <= '0;
      max_out   <= '0;
`endif
    end else if (flush) begin
      // Flush beats any handshake; a sample offered now is dropped.
      state     <= IDLE;
      fill_cnt  <= '0;
      pass_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            win <= win_sh;
            if (fill_cnt != FW'(N)) fill_cnt <= fill_cnt + FW'(1);
            if (full_after) begin
              srt      <= win_sh;
              pass_cnt <= '0;
              in_ready <= 1'b0;
              state    <= SORT;
            end
          end
        end
        SORT: begin
          srt      <= srt_nxt;
          pass_cnt <= pass_cnt + PW'(1);
          if (last_pass) begin
            // Outputs are taken from the final pass result directly.
            state     <= OUT;
            out_valid <= 1'b1;
            data_out  <= srt_nxt[MID];
`ifdef MEDIAN_MINMAX_EN
            min_out   <= srt_nxt[0];
            max_out   <= srt_nxt[N-1];
`endif
          end
        end
        OUT: begin
          // Hold the result until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_median_window_filter.sv
// tb_median_window_filter
//   Directed scenarios followed by a randomized stream. The reference model
//   is a queue holding the last N samples; the expected median, minimum and
//   maximum come from sorting a copy of that queue.
module tb_median_window_filter;
  localparam int W = 8;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] data_out;
`ifdef MEDIAN_MINMAX_EN
  logic [W-1:0] min_out;
  logic [W-1:0] max_out;
`endif

  int checks = 0;
  int failures = 0;
  int win_q[$];
  int exp_med, exp_min, exp_max;

  always #5 clk = ~clk;

  median_window_filter #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef MEDIAN_MINMAX_EN
    ,
    .min_out   (min_out),
    .max_out   (max_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: window of the last N accepted samples.
  task automatic model_push(input int s, output bit full);
    int t[$];
    full = 1'b0;
    win_q.push_front(s);
    if (win_q.size() > N) void'(win_q.pop_back());
    if (win_q.size() == N) begin
      t = win_q;
      t.sort();
      exp_med = t[N/2];
      exp_min = t[0];
      exp_max = t[N-1];
      full = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic accept(input logic [W-1:0] s, output bit full);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    data_in  = s;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    model_push(s, full);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * N) begin
      chk("sort_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  // Collect the result (if any) with d cycles of backpressure first.
  task automatic collect(input int d, input bit full);
    int lat;
    logic [W-1:0] held;
    if (!full) begin
      chk("no_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);
      return;
    end
    wait_out(lat);
    chk("latency", lat, N);
    chk("median", data_out, exp_med);
`ifdef MEDIAN_MINMAX_EN
    chk("min", min_out, exp_min);
    chk("max", max_out, exp_max);
`endif
    held = data_out;
    for (int i = 0; i < d; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", data_out, held);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask

  task automatic push(input logic [W-1:0] s, input int d);
    bit f;
    accept(s, f);
    collect(d, f);
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'd99;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    win_q.delete();
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_ready"}, in_ready, 0);
`ifdef MEDIAN_MINMAX_EN
    chk({tag, "_min"}, min_out, 0);
    chk({tag, "_max"}, max_out, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    win_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_rel_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit f;
    int lat;
    logic [W-1:0] v;

    // Reset state.
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // Basic fill and sliding.
    push(8'd10, 0); push(8'd50, 0); push(8'd30, 0); push(8'd20, 0);
    push(8'd40, 0);
    push(8'd60, 0);
    push(8'd40, 0); push(8'd40, 0);

    // Backpressure.
    push(8'd5, 10);

    // Flush with a partial window.
    do_flush();
    push(8'd9, 0); push(8'd8, 0); push(8'd7, 0);
    do_flush();
    for (int i = 1; i <= 5; i++) push(W'(i), 0);

    // Min/max corner values.
    do_flush();
    push(8'd7, 0); push(8'd255, 0); push(8'd0, 0); push(8'd128, 0);
    push(8'd3, 0);

    // Reset during SORT.
    for (int i = 0; i < 4; i++) push(8'd200, 0);
    accept(8'd201, f);
    @(posedge clk);
    @(posedge clk);
    async_reset("rst_sort");
    push(8'd11, 0); push(8'd12, 0); push(8'd13, 0); push(8'd14, 0);
    push(8'd15, 0);

    // Reset during OUT under backpressure.
    accept(8'd100, f);
    wait_out(lat);
    chk("out_before_rst", out_valid, 1);
    async_reset("rst_out");
    for (int i = 0; i < 5; i++) push(W'(20 + i), 0);

    // Randomized stream with duplicates, extremes and occasional flushes.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_flush();
      end else begin
        if ($urandom_range(0, 2) == 0) v = W'($urandom_range(0, 3) * 85);
        else v = W'($urandom_range(0, 255));
        push(v, int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
